// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one external memory bus between instruction and data
//            requesters; sequences read bursts and write responses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cached,
    output logic        inst_addr_ok,
    output logic        inst_rvalid,
    output logic        inst_rlast,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic        data_cached,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_rvalid,
    output logic        data_rlast,
    output logic        data_wdone,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rlast,
    input  logic        bus_wdone,
    output logic        proto_err
);

    localparam int          c_off_bits   = $clog2(LINE_WORDS * 4);
    localparam logic [31:0] c_line_mask  = ~((32'd1 << c_off_bits) - 32'd1);
    localparam logic [3:0]  c_refill_len = 4'(LINE_WORDS - 1);
    localparam logic        c_own_inst   = 1'b0;
    localparam logic        c_own_data   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_wr_q, bus_wr_d;
    logic [3:0]  bus_len_q, bus_len_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        proto_err_q, proto_err_d;
    logic        data_wdone_q, data_wdone_d;

    logic        w_grant_data;
    logic        w_accept;
    logic        w_beat;
    logic        w_cnt_at_len;
    logic        w_last_beat;

    // Round-robin only matters on contention: the side that did not own the bus last goes next.
    assign w_grant_data = data_req & (~inst_req | (last_owner_q == c_own_inst));
    assign w_accept     = (state_q == S_ADDR) & bus_req_q & bus_addr_ok;
    assign w_beat       = (state_q == S_RDATA) & bus_rvalid;
    assign w_cnt_at_len = (cnt_q == bus_len_q);
    assign w_last_beat  = w_beat & w_cnt_at_len;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_len_d    = bus_len_q;
        bus_addr_d   = bus_addr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;
        proto_err_d  = proto_err_q;
        data_wdone_d = 1'b0;

        // Any response while no data phase is open means the bus is out of step with us.
        if (((state_q == S_IDLE) || (state_q == S_ADDR)) && (bus_rvalid || bus_wdone)) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    bus_req_d = 1'b1;
                    state_d   = S_ADDR;
                    if (w_grant_data) begin
                        owner_d     = c_own_data;
                        bus_wr_d    = data_wr;
                        bus_wstrb_d = data_wstrb;
                        bus_wdata_d = data_wdata;
                        if (!data_wr && data_cached) begin
                            bus_addr_d = data_addr & c_line_mask;
                            bus_len_d  = c_refill_len;
                        end else begin
                            bus_addr_d = data_addr;
                            bus_len_d  = 4'd0;
                        end
                    end else begin
                        owner_d     = c_own_inst;
                        bus_wr_d    = 1'b0;
                        bus_wstrb_d = 4'd0;
                        bus_wdata_d = 32'd0;
                        if (inst_cached) begin
                            bus_addr_d = inst_addr & c_line_mask;
                            bus_len_d  = c_refill_len;
                        end else begin
                            bus_addr_d = inst_addr;
                            bus_len_d  = 4'd0;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    bus_req_d    = 1'b0;
                    last_owner_d = owner_q;
                    cnt_d        = 4'd0;
                    state_d      = bus_wr_q ? S_WRESP : S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_beat) begin
                    if (bus_rlast != w_cnt_at_len) begin
                        proto_err_d = 1'b1;
                    end
                    // Completion follows our own beat count, not the bus's rlast.
                    if (w_cnt_at_len) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_WRESP: begin
                if (bus_wdone) begin
                    data_wdone_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= c_own_inst;
            last_owner_q <= c_own_data;
            cnt_q        <= 4'd0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_len_q    <= 4'd0;
            bus_addr_q   <= 32'd0;
            bus_wstrb_q  <= 4'd0;
            bus_wdata_q  <= 32'd0;
            proto_err_q  <= 1'b0;
            data_wdone_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_len_q    <= bus_len_d;
            bus_addr_q   <= bus_addr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
            proto_err_q  <= proto_err_d;
            data_wdone_q <= data_wdone_d;
        end
    end

    assign inst_addr_ok = w_accept & (owner_q == c_own_inst);
    assign data_addr_ok = w_accept & (owner_q == c_own_data);
    assign inst_rvalid  = w_beat & (owner_q == c_own_inst);
    assign data_rvalid  = w_beat & (owner_q == c_own_data);
    assign inst_rlast   = w_last_beat & (owner_q == c_own_inst);
    assign data_rlast   = w_last_beat & (owner_q == c_own_data);
    assign data_wdone   = data_wdone_q;
    assign rdata        = (state_q == S_RDATA) ? bus_rdata : 32'd0;

    assign bus_req      = bus_req_q;
    assign bus_wr       = bus_wr_q;
    assign bus_len      = bus_len_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wstrb    = bus_wstrb_q;
    assign bus_wdata    = bus_wdata_q;
    assign proto_err    = proto_err_q;

endmodule
`default_nettype wire
